// File: rtl/macc_pkg.sv
// Shared definitions for the matrix-accelerator sequencer.
// Contents:
//   state_t            - sequencer state encoding
//   BUF_A/BUF_B/BUF_C  - bit positions of the A, B and C buffers in the wen/ren strobe vectors
//   log2_dim()         - ceil(log2) helper used to split the counter into {i,j,k}
package macc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_LOAD_B  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_FLUSH   = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic [1:0] BUF_A = 2'd0;
    localparam logic [1:0] BUF_B = 2'd1;
    localparam logic [1:0] BUF_C = 2'd2;

    // Number of bits needed to index dim entries (dim is a power of two).
    function automatic int log2_dim(input int dim);
        int r;
        r = 32'sd0;
        for (int b = 0; b < 31; b++) begin
            if ((32'sd1 << b) < dim) begin
                r = b + 32'sd1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/macc_seq_if.sv
// Handshake and buffer-control bundle between the sequencer and its environment.
// master: the sequencer (drives status, in_ready, out_valid, buffer strobes/addresses, MAC controls)
// slave : the environment (drives start, in_valid, out_ready; observes everything else)
interface macc_seq_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic              busy;
    logic              done;
    logic              in_valid;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        wen;
    logic [2:0]        ren;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [ADDR_W-1:0] addr_c;
    logic              mac_clr;
    logic              mac_en;

    modport master (
        input  start, in_valid, out_ready,
        output busy, done, in_ready, out_valid, wen, ren,
               addr_a, addr_b, addr_c, mac_clr, mac_en
    );

    modport slave (
        output start, in_valid, out_ready,
        input  busy, done, in_ready, out_valid, wen, ren,
               addr_a, addr_b, addr_c, mac_clr, mac_en
    );
endinterface

// File: rtl/macc_delay_line.sv
// Fixed-depth shift register that carries {valid, addr_c} from the last MAC
// issue of an element to the cycle its accumulated result reaches the C buffer.
// Ports:
//   clk, rst (sync, active-high) - clock and reset; reset empties every stage
//   din  [WIDTH]                 - entry captured every cycle
//   dout [WIDTH]                 - entry captured DEPTH cycles earlier
module macc_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift one stage per cycle; reset flushes pending writes so none escape after an abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_r[s] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= din;
            for (int s = 1; s < DEPTH; s++) begin
                stage_r[s] <= stage_r[s-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/macc_seq.sv
// Matrix-accelerator sequencer: loads A then B, issues the DIM^3 MAC read
// schedule, writes C after MAC_LAT cycles, then drains C over valid/ready.
// Ports:
//   clk, rst (sync, active-high)
//   bus (macc_seq_if.master): start/busy/done, input stream handshake,
//       output stream handshake, buffer wen/ren/addresses, mac_clr/mac_en
module macc_seq
    import macc_pkg::*;
#(
    parameter int DIM     = 4,
    parameter int ADDR_W  = 4,
    parameter int MAC_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    macc_seq_if.master bus
);

    localparam int L     = log2_dim(DIM);
    localparam int CNT_W = 3 * L;
    localparam int FL    = MAC_LAT - 32'sd1;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FL);

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              rd_done_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              done_r;
    logic              in_ready_r;

    logic [L-1:0]      i_s, j_s, k_s;
    logic [ADDR_W-1:0] ld_addr_s;
    logic              accept_s, ld_last_s, cmp_last_s, flush_last_s;
    logic              rd_issue_s, out_accept_s;
    logic [ADDR_W:0]   dl_in_s, dl_out_s;

    logic [2:0]        wen_s, ren_s;
    logic [ADDR_W-1:0] addr_a_s, addr_b_s, addr_c_s;
    logic              mac_clr_s, mac_en_s;

    // cnt doubles as load index, {i,j,k} issue counter, flush timer and drain read index.
    assign k_s          = cnt_r[L-1:0];
    assign j_s          = cnt_r[2*L-1:L];
    assign i_s          = cnt_r[3*L-1:2*L];
    assign ld_addr_s    = cnt_r[ADDR_W-1:0];
    assign ld_last_s    = &ld_addr_s;
    assign cmp_last_s   = &cnt_r;
    assign flush_last_s = (cnt_r == FLUSH_LAST);
    assign accept_s     = bus.in_valid & in_ready_r;
    // At most one C word is in flight, so a read may issue whenever the output slot frees up.
    assign rd_issue_s   = (state_r == ST_DRAIN) & ~rd_done_r & (~out_valid_r | bus.out_ready);
    assign out_accept_s = out_valid_r & bus.out_ready;

    // The final k of each element schedules the C write for {i,j}.
    assign dl_in_s = {(state_r == ST_COMPUTE) & (&k_s), i_s, j_s};

    macc_delay_line #(
        .DEPTH (MAC_LAT),
        .WIDTH (ADDR_W + 1)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (dl_in_s),
        .dout (dl_out_s)
    );

    // Sequencer FSM, shared counter and the registered status/handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            rd_done_r   <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_r    <= ST_LOAD_A;
                        cnt_r      <= {CNT_W{1'b0}};
                        busy_r     <= 1'b1;
                        in_ready_r <= 1'b1;
                    end
                end
                ST_LOAD_A: begin
                    if (accept_s) begin
                        if (ld_last_s) begin
                            state_r <= ST_LOAD_B;
                            cnt_r   <= {CNT_W{1'b0}};
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (accept_s) begin
                        if (ld_last_s) begin
                            state_r    <= ST_COMPUTE;
                            cnt_r      <= {CNT_W{1'b0}};
                            in_ready_r <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_COMPUTE: begin
                    // Natural wrap returns cnt to zero after the all-ones issue.
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cmp_last_s) begin
                        state_r <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (flush_last_s) begin
                        state_r   <= ST_DRAIN;
                        cnt_r     <= {CNT_W{1'b0}};
                        rd_done_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (rd_issue_s) begin
                        cnt_r       <= cnt_r + CNT_ONE;
                        out_valid_r <= 1'b1;
                        if (ld_last_s) begin
                            rd_done_r <= 1'b1;
                        end
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                    // With every read issued, the accepted word is the last one.
                    if (out_accept_s && rd_done_r) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    rd_done_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Buffer strobe/address decode; combinational so writes coincide with the input accept and reads with the output slot freeing.
    always_comb begin
        wen_s     = 3'b000;
        ren_s     = 3'b000;
        addr_a_s  = {ADDR_W{1'b0}};
        addr_b_s  = {ADDR_W{1'b0}};
        addr_c_s  = {ADDR_W{1'b0}};
        mac_clr_s = 1'b0;
        mac_en_s  = 1'b0;
        if (rst) begin
            // An abort silences every strobe immediately.
            wen_s = 3'b000;
        end else begin
            case (state_r)
                ST_LOAD_A: begin
                    wen_s[BUF_A] = accept_s;
                    addr_a_s     = ld_addr_s;
                end
                ST_LOAD_B: begin
                    wen_s[BUF_B] = accept_s;
                    addr_b_s     = ld_addr_s;
                end
                ST_COMPUTE: begin
                    ren_s[BUF_A] = 1'b1;
                    ren_s[BUF_B] = 1'b1;
                    mac_en_s     = 1'b1;
                    mac_clr_s    = (k_s == {L{1'b0}});
                    addr_a_s     = {i_s, k_s};
                    addr_b_s     = {k_s, j_s};
                end
                ST_DRAIN: begin
                    if (rd_issue_s) begin
                        ren_s[BUF_C] = 1'b1;
                        addr_c_s     = ld_addr_s;
                    end else begin
                        ren_s[BUF_C] = 1'b0;
                    end
                end
                default: begin
                    wen_s = 3'b000;
                end
            endcase
            if (dl_out_s[ADDR_W]) begin
                wen_s[BUF_C] = 1'b1;
                addr_c_s     = dl_out_s[ADDR_W-1:0];
            end else begin
                wen_s[BUF_C] = 1'b0;
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.wen       = wen_s;
    assign bus.ren       = ren_s;
    assign bus.addr_a    = addr_a_s;
    assign bus.addr_b    = addr_b_s;
    assign bus.addr_c    = addr_c_s;
    assign bus.mac_clr   = mac_clr_s;
    assign bus.mac_en    = mac_en_s;

endmodule

// File: doc/macc_seq.md
Name: macc_seq

Overview:
Sequencer for the matrix accelerator's three 32-bit matrix buffers (A, B, C).
- Streams A then B into their buffers.
- Issues the DIM³ multiply-accumulate read schedule to the MAC datapath and writes each C element after the datapath pipeline latency.
- Drains C row-major over a valid/ready stream.
- Drives the buffers' wen/ren strobes and addresses; holds no matrix data itself.

Parameters:
DIM, 4, matrix dimension; power of two, 2..16
ADDR_W, 4, buffer address width; must equal log2(DIM*DIM)
MAC_LAT, 2, cycles from the last mac_en of an element to its accumulator result being valid at the C buffer write port (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin operation; honoured only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the last C word is accepted
in_valid  in  1  input word (A then B, row-major) present
in_ready  out  1  controller accepts input word
out_valid  out  1  C word valid on C buffer read data
out_ready  in  1  consumer accepts C word
wen  out  3  buffer write strobes; bit0 A, bit1 B, bit2 C
ren  out  3  buffer read strobes; same bit mapping
addr_a  out  ADDR_W  A buffer address
addr_b  out  ADDR_W  B buffer address
addr_c  out  ADDR_W  C buffer address
mac_clr  out  1  clear accumulator with this product (first k of an element)
mac_en  out  1  accumulate product of this cycle's A/B reads

Behaviour:
- Reset value of every output is 0. Reset also clears all counters and the delay line and forces IDLE. Reset mid-operation aborts with no further strobes.
- States: IDLE, LOAD_A, LOAD_B, COMPUTE, FLUSH, DRAIN, DONE.
- IDLE:
  - in_ready=0; in_valid and out_ready are ignored.
  - start=1 -> LOAD_A with cnt=0.
  - start in any other state is ignored.
- LOAD_A / LOAD_B:
  - in_ready=1.
  - Each accept (in_valid&in_ready) pulses wen[0] (or wen[1]) in the same cycle, with addr_a/addr_b = cnt, then increments cnt.
  - Accept at cnt=DIM²-1: cnt wraps to 0 and the state advances (LOAD_A -> LOAD_B -> COMPUTE).
  - Gaps in in_valid simply stall.
- COMPUTE:
  - One issue per cycle, no stalls, DIM³ cycles.
  - cnt is split as {i,j,k} (each log2(DIM) bits, k LSB).
  - ren[0]=ren[1]=mac_en=1, addr_a={i,k}, addr_b={k,j}, mac_clr=(k==0).
  - At k==DIM-1, {1,{i,j}} enters the MAC_LAT-deep delay line.
  - Delay-line output drives wen[2] and addr_c (addr_c = 0 when not writing).
  - Last issue (cnt all ones) -> FLUSH; cnt wraps to 0.
- FLUSH:
  - No issues; the delay line continues to shift.
  - Exactly MAC_LAT cycles, then DRAIN.
  - The last C write occurs in the final FLUSH cycle.
- DRAIN:
  - Buffer read latency is 1 cycle. The buffer holds read data while ren is low.
  - Read rule: issue ren[2]=1, addr_c=cnt when (!out_valid | out_ready) and reads remain.
  - out_valid is set the cycle after a read is issued and cleared on accept with no new read.
  - The cycle after the accept of word DIM²-1 -> DONE.
  - out_valid is never dropped without an accept; data is stable while stalled.
- DONE: done=1 for one cycle, busy=1, then IDLE.
- Counter wrap: all counters are power-of-two width and wrap naturally; no explicit compare except all-ones.
- Cycle count at zero back-pressure:
  - Load: 2·DIM² accepts.
  - Compute + flush: DIM³+MAC_LAT cycles.
  - Drain: DIM²+1 cycles.
  - Done: 1 cycle.

Decomposition:
- macc_pkg:
  - state enum
  - buffer index constants BUF_A=0, BUF_B=1, BUF_C=2
  - log2 helper for DIM
- Sub-module macc_delay_line: parameterised depth/width shift register with sync reset, carrying {valid, addr_c}.
- Counters, FSM and output decode live in macc_seq.

Test Plan:
1. rst held 3 cycles, with start/in_valid toggling -> all outputs 0, busy=0; start after reset release -> LOAD_A, in_ready=1 next cycle.
2. DIM=2, MAC_LAT=2, behavioural buffers+MAC, A=[1,2,3,4], B=[5,6,7,8] -> out stream 19,22,43,50; done pulses once; busy low the following cycle.
3. DIM=2 COMPUTE first 4 issues -> (addr_a,addr_b) = (0,0),(1,2),(0,1),(1,3); mac_clr=1 on issues 0 and 2; wen[2] with addr_c=0 exactly 2 cycles after issue 1.
4. DIM=4, A=identity, B=0..15, in_valid random 50% and out_ready random 50% -> C=0..15 in order; no dropped or duplicated word; out data constant while out_valid&!out_ready.
5. start pulsed during LOAD_B and COMPUTE -> no effect; result as scenario 2.
6. rst asserted mid-COMPUTE (cnt=5) -> next cycle IDLE, all strobes 0, no further wen[2]; full new run with scenario 2 data -> correct result.
